traffic_phase_scheduler: RTL and testbench

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

---
 rtl/traffic_phase_scheduler.sv | 127 ++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Four-approach traffic phase scheduler: round-robin green grants with
// min/max green, yellow and all-red clearance, and latched vehicle requests.
module traffic_phase_scheduler #(
   parameter int MIN_GREEN = 10,
   parameter int MAX_GREEN = 40,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] presence,
   input  logic [3:0] congest,
   output logic [3:0] green,
   output logic [3:0] yellow,
   output logic [1:0] state,
   output logic [1:0] cur_phase,
   output logic [7:0] elapsed
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GREEN  = 2'b01,
      YELLOW = 2'b10,
      ALLRED = 2'b11
   } sched_state_t;

   localparam logic [7:0] MIN_M1 = 8'(MIN_GREEN - 1);
   localparam logic [7:0] MAX_M1 = 8'(MAX_GREEN - 1);
   localparam logic [7:0] YEL_M1 = 8'(YELLOW_T - 1);
   localparam logic [7:0] AR_M1  = 8'(ALLRED_T - 1);

   sched_state_t state_r, state_n;
   logic [3:0]   pending, pending_n;
   logic [3:0]   req;
   logic [1:0]   sel, idx, phase_n;
   logic         found, grant, green_done;
   logic [3:0]   grant_mask, hold_mask;
   logic [3:0]   green_n, yellow_n;
   logic [7:0]   elapsed_n;

   // Round-robin search starts just after the current phase, so the
   // current phase itself is considered last.
   always_comb begin
      req   = pending | presence;
      sel   = cur_phase;
      found = 1'b0;
      idx   = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         idx = cur_phase + 2'(i);
         if (!found && req[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_n    = state_r;
      phase_n    = cur_phase;
      grant      = 1'b0;
      green_done = ((elapsed >= MIN_M1) && !congest[cur_phase]) ||
                   (elapsed == MAX_M1);
      case (state_r)
         IDLE: begin
            if (found) begin
               state_n = GREEN;
               phase_n = sel;
               grant   = 1'b1;
            end
         end
         GREEN: begin
            if (green_done) state_n = YELLOW;
         end
         YELLOW: begin
            if (elapsed == YEL_M1) state_n = ALLRED;
         end
         ALLRED: begin
            if (elapsed == AR_M1) begin
               if (found) begin
                  state_n = GREEN;
                  phase_n = sel;
                  grant   = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // A grant clears its own request even if presence is still asserted.
      grant_mask = grant ? 4'(4'b0001 << sel) : 4'b0000;
      hold_mask  = (state_r == GREEN) ? 4'(4'b0001 << cur_phase) : 4'b0000;
      pending_n  = (pending | (presence & ~hold_mask)) & ~grant_mask;

      if (state_n != state_r)
         elapsed_n = 8'd0;
      else if (elapsed == 8'hFF)
         elapsed_n = elapsed;
      else
         elapsed_n = elapsed + 8'd1;

      green_n  = (state_n == GREEN)  ? 4'(4'b0001 << phase_n) : 4'b0000;
      yellow_n = (state_n == YELLOW) ? 4'(4'b0001 << phase_n) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         cur_phase <= 2'd3;
         elapsed   <= 8'd0;
         pending   <= 4'b0000;
         green     <= 4'b0000;
         yellow    <= 4'b0000;
      end else begin
         state_r   <= state_n;
         cur_phase <= phase_n;
         elapsed   <= elapsed_n;
         pending   <= pending_n;
         green     <= green_n;
         yellow    <= yellow_n;
      end
   end

   assign state = state_r;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: directed scenarios plus
// randomized traffic compared every cycle against a duration-based model.
module tb_traffic_phase_scheduler;

   localparam int MIN_G = 10;
   localparam int MAX_G = 40;
   localparam int YEL_T = 3;
   localparam int AR_T  = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] presence = 4'b0;
   logic [3:0] congest = 4'b0;
   logic [3:0] green, yellow;
   logic [1:0] state, cur_phase;
   logic [7:0] elapsed;

   int checks = 0;
   int errors = 0;

   // Reference model: 0 idle, 1 green, 2 yellow, 3 all-red.
   int         m_state = 0;
   int         m_phase = 3;
   int         m_elapsed = 0;
   logic [3:0] m_pend = 4'b0;

   traffic_phase_scheduler #(
      .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_T(YEL_T), .ALLRED_T(AR_T)
   ) dut (
      .clk(clk), .rst(rst), .presence(presence), .congest(congest),
      .green(green), .yellow(yellow), .state(state),
      .cur_phase(cur_phase), .elapsed(elapsed)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed %0d expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   function automatic int rrPick(input logic [3:0] r, input int ph);
      for (int k = 1; k <= 4; k++) begin
         if (r[(ph + k) % 4]) return (ph + k) % 4;
      end
      return -1;
   endfunction

   task automatic modelStep(input logic r, input logic [3:0] p, input logic [3:0] c);
      int         nxt;
      int         pick;
      int         spent;
      logic [3:0] latch;
      if (r) begin
         m_state = 0; m_phase = 3; m_elapsed = 0; m_pend = 4'b0;
         return;
      end
      pick  = rrPick(m_pend | p, m_phase);
      spent = m_elapsed + 1;
      nxt   = m_state;
      latch = p;
      if (m_state == 1) latch[m_phase] = 1'b0;
      m_pend = m_pend | latch;
      case (m_state)
         0: if (pick >= 0) nxt = 1;
         1: if ((spent >= MIN_G && !c[m_phase]) || spent == MAX_G) nxt = 2;
         2: if (spent == YEL_T) nxt = 3;
         default: if (spent == AR_T) nxt = (pick >= 0) ? 1 : 0;
      endcase
      if (nxt == 1 && m_state != 1) begin
         m_phase = pick;
         m_pend[pick] = 1'b0;
      end
      m_elapsed = (nxt != m_state) ? 0 : ((m_elapsed >= 255) ? 255 : m_elapsed + 1);
      m_state = nxt;
   endtask

   // One clock: drive inputs, advance the model on the edge, compare after it.
   task automatic applyStimulus(input logic r, input logic [3:0] p, input logic [3:0] c);
      rst = r; presence = p; congest = c;
      @(posedge clk);
      modelStep(r, p, c);
      #1;
      checkOutput("state", int'(state), m_state);
      checkOutput("green", int'(green), (m_state == 1) ? (1 << m_phase) : 0);
      checkOutput("yellow", int'(yellow), (m_state == 2) ? (1 << m_phase) : 0);
      checkOutput("cur_phase", int'(cur_phase), m_phase);
      checkOutput("elapsed", int'(elapsed), m_elapsed);
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 4'b0, 4'b0);
      applyStimulus(1'b1, 4'b0, 4'b0);
   endtask

   task automatic measureRun(input logic [3:0] g, input logic [3:0] c, output int n);
      n = 0;
      while (green == g && n < 300) begin
         n++;
         applyStimulus(1'b0, 4'b0, c);
      end
   endtask

   task automatic measureGap(output int n);
      n = 0;
      while (green == 4'b0 && state != 2'b00 && n < 300) begin
         n++;
         applyStimulus(1'b0, 4'b0, 4'b0);
      end
   endtask

   initial begin
      int n;
      logic [3:0] cg;
      #2;

      // Idle after reset, then elapsed saturates while idle.
      doReset();
      checkOutput("rst_state", int'(state), 0);
      checkOutput("rst_phase", int'(cur_phase), 3);
      checkOutput("rst_elapsed", int'(elapsed), 0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 4'b0, 4'b0);
      checkOutput("idle_elapsed20", int'(elapsed), 20);
      for (int i = 0; i < 250; i++) applyStimulus(1'b0, 4'b0, 4'b0);
      checkOutput("idle_saturate", int'(elapsed), 255);

      // Single pulse on NS1.
      doReset();
      applyStimulus(1'b0, 4'b0001, 4'b0);
      measureRun(4'b0001, 4'b0, n);
      checkOutput("pulse_green_len", n, MIN_G);
      n = 0;
      while (yellow == 4'b0001 && n < 300) begin n++; applyStimulus(1'b0, 4'b0, 4'b0); end
      checkOutput("pulse_yellow_len", n, YEL_T);
      n = 0;
      while (state == 2'b11 && n < 300) begin n++; applyStimulus(1'b0, 4'b0, 4'b0); end
      checkOutput("pulse_allred_len", n, AR_T);
      checkOutput("pulse_end_idle", int'(state), 0);

      // Max green under held congestion.
      doReset();
      applyStimulus(1'b0, 4'b0001, 4'b0001);
      measureRun(4'b0001, 4'b0001, n);
      checkOutput("max_green_len", n, MAX_G);
      checkOutput("max_then_yellow", int'(yellow), 1);

      // Early release when congestion drops at elapsed 15.
      doReset();
      applyStimulus(1'b0, 4'b0001, 4'b0001);
      n = 0;
      while (green == 4'b0001 && n < 300) begin
         n++;
         cg = (elapsed >= 8'd15) ? 4'b0000 : 4'b0001;
         applyStimulus(1'b0, 4'b0, cg);
      end
      checkOutput("early_green_len", n, 16);

      // Round-robin service of all four approaches.
      doReset();
      applyStimulus(1'b0, 4'b1111, 4'b0);
      for (int k = 0; k < 4; k++) begin
         checkOutput("rr_grant", int'(green), 1 << k);
         measureRun(4'(1 << k), 4'b0, n);
         checkOutput("rr_green_len", n, MIN_G);
         measureGap(n);
         checkOutput("rr_gap_len", n, YEL_T + AR_T);
      end
      checkOutput("rr_end_idle", int'(state), 0);

      // Reset during yellow with NS2/EW1 pending.
      doReset();
      applyStimulus(1'b0, 4'b0111, 4'b0);
      n = 0;
      while (state != 2'b10 && n < 300) begin n++; applyStimulus(1'b0, 4'b0, 4'b0); end
      checkOutput("midrst_in_yellow", int'(state), 2);
      applyStimulus(1'b1, 4'b0, 4'b0);
      checkOutput("midrst_state", int'(state), 0);
      checkOutput("midrst_yellow", int'(yellow), 0);
      checkOutput("midrst_phase", int'(cur_phase), 3);
      for (int i = 0; i < 30; i++) applyStimulus(1'b0, 4'b0, 4'b0);
      checkOutput("midrst_no_green", int'(green), 0);
      applyStimulus(1'b0, 4'b0100, 4'b0);
      checkOutput("midrst_new_grant", int'(green), 4'b0100);

      // Randomized traffic against the model.
      cg = 4'b0;
      for (int i = 0; i < 3000; i++) begin
         logic       r;
         logic [3:0] p;
         r = ($urandom_range(0, 399) == 0);
         p = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
         if ($urandom_range(0, 19) == 0) cg = 4'($urandom_range(0, 15));
         applyStimulus(r, p, cg);
         checkOutput("one_light", int'((green != 0) && (yellow != 0)), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
